// File: rtl/dma_word_packer.sv
// dma_word_packer
// Packs variable-width byte chunks (1..8 bytes) from a DMA stream into
// 8-byte output beats. The first stream byte lands in bits [7:0] of a beat.
// A frame ends with an in_last chunk; the tail of the frame is flushed as a
// final, possibly partial, beat flagged with out_last.
//
// Optional feature macro: DMA_WORD_PACKER_STATS_EN
//   defined   -> beat_count / drop_count are live 16-bit wrapping counters
//   undefined -> both counters are tied to zero and no registers exist
//
// Handshake semantics (both ports): a transfer happens on a rising clk edge
// where valid and ready are both high. While out_valid is high and out_ready
// is low, out_data/out_bytes/out_last are held stable. in_ready and
// out_valid are decoded from registered state only, so neither depends
// combinationally on the opposite side of its handshake.

module dma_word_packer #(
  parameter int DEBUG = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] in_data,
  input  logic [3:0]  in_width,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_last,
  output logic [63:0] out_data,
  output logic [3:0]  out_bytes,
  output logic        out_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] beat_count,
  output logic [15:0] drop_count
);

  localparam logic [0:0] ST_FILL  = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  logic [127:0] acc;
  logic [4:0]   fill;
  logic [0:0]   state;

  logic [127:0] acc_shift, acc_next;
  logic [4:0]   fill_shift, fill_next;
  logic [0:0]   state_next;
  logic [63:0]  in_masked;
  logic         in_fire, out_fire, width_ok;

  assign width_ok  = (in_width != 4'd0) && (in_width <= 4'd8);
  assign in_ready  = (state == ST_FILL) && (fill <= 5'd8);
  assign out_valid = (fill >= 5'd8) || ((state == ST_FLUSH) && (fill != 5'd0));
  assign out_last  = (state == ST_FLUSH) && (fill <= 5'd8);
  assign out_bytes = (fill >= 5'd8) ? 4'd8 : fill[3:0];
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // Present accumulator bytes 0..7, zeroing lanes at or above fill.
  always_comb begin
    out_data = '0;
    for (int b = 0; b < 8; b++) begin
      if (5'(b) < fill) out_data[b*8 +: 8] = acc[b*8 +: 8];
    end
  end

  // Keep only the significant low in_width bytes of the incoming chunk.
  always_comb begin
    in_masked = '0;
    for (int b = 0; b < 8; b++) begin
      if (4'(b) < in_width) in_masked[b*8 +: 8] = in_data[b*8 +: 8];
    end
  end

  // Next state: beat shift first, then chunk append at the shifted fill.
  always_comb begin
    acc_shift  = acc;
    fill_shift = fill;
    state_next = state;
    if (out_fire) begin
      if (out_last) begin
        // Final beat of the frame: everything left is consumed.
        acc_shift  = '0;
        fill_shift = '0;
        state_next = ST_FILL;
      end else begin
        // A non-final beat always carries a full 8 bytes.
        acc_shift  = {64'h0, acc[127:64]};
        fill_shift = fill - 5'd8;
      end
    end
    acc_next  = acc_shift;
    fill_next = fill_shift;
    if (in_fire) begin
      if (width_ok) begin
        // Bytes above fill are always zero, so OR-in is a safe append.
        acc_next  = acc_shift | ({64'h0, in_masked} << {fill_shift, 3'b000});
        fill_next = fill_shift + {1'b0, in_width};
        if (in_last) state_next = ST_FLUSH;
      end else if (in_last && (fill_shift != 5'd0)) begin
        // Dropped chunk still closes the frame if data is pending.
        state_next = ST_FLUSH;
      end
    end
  end

  // Accumulator, fill level and frame state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      fill  <= '0;
      state <= ST_FILL;
    end else begin
      acc   <= acc_next;
      fill  <= fill_next;
      state <= state_next;
    end
  end

`ifdef DMA_WORD_PACKER_STATS_EN
  logic [15:0] beat_cnt, drop_cnt;

  // Free-running wrap-around counters of emitted beats and dropped chunks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (out_fire)              beat_cnt <= beat_cnt + 16'd1;
      if (in_fire && !width_ok)  drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign beat_count = beat_cnt;
  assign drop_count = drop_cnt;
`else
  assign beat_count = 16'd0;
  assign drop_count = 16'd0;
`endif

`ifndef SYNTHESIS
  // Trace beat emission and dropped chunks when DEBUG is enabled.
  always @(posedge clk) begin
    if ((DEBUG != 0) && !rst) begin
      if (out_fire)
        $display("dma_word_packer: beat data=%h bytes=%0d last=%0b",
                 out_data, out_bytes, out_last);
      if (in_fire && !width_ok)
        $display("dma_word_packer: dropped chunk width=%0d last=%0b",
                 in_width, in_last);
    end
  end
`endif

endmodule
